// File: rtl/rni_lcrd_pkg.sv
// Shared definitions for the RNI link-credit manager: FSM encoding and
// the counter-width derivation used by the top level.
package rni_lcrd_pkg;

  // Link-credit FSM state, shared by all channels.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STOP  = 2'd3
  } lcrd_state_e;

  // Bits needed to hold every count from 0 up to max_val inclusive.
  function automatic int lcrd_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rni_lcrd_ch_ctr.sv
// One saturating link-credit counter. The top level decides which of
// load/inc/dec/ret are meaningful in the current FSM state; this block only
// applies them and reports saturation events as single-cycle pulses.
module rni_lcrd_ch_ctr #(
  parameter int CNT_W    = 4,
  parameter int INIT_VAL = 4,
  parameter int MAX_VAL  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             ret_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             not_zero_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;
  logic             at_max;

  // A consumed credit and a returned credit both remove one from the pool.
  assign take       = dec_i | ret_i;
  assign at_max     = (cnt_q == CNT_W'(MAX_VAL));
  assign not_zero_o = |cnt_q;
  assign cnt_o      = cnt_q;

  // Next count: load wins, simultaneous add/remove cancels, edges saturate.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (load_i) begin
      cnt_d = CNT_W'(INIT_VAL);
    end else if (inc_i && !take) begin
      if (at_max) ovf_o = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (take && !inc_i) begin
      if (!not_zero_o) unf_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rni_lcrd_mgr.sv
// Multi-channel CHI L-credit manager for the RNI transmit side. A single
// INIT/RUN/DRAIN/STOP FSM governs NUM_CH per-channel counters; DRAIN hands
// every held credit back to the link layer before deact_done is raised.
module rni_lcrd_mgr
  import rni_lcrd_pkg::*;
#(
  parameter int  NUM_CH            = 4,
  parameter int  LCRD_INIT_CNT_VAL = 4,
  parameter int  LCRD_MAX_CNT_VAL  = 15,
  localparam int CNT_W             = lcrd_cnt_w(LCRD_MAX_CNT_VAL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       lcrd_inc,
  input  logic [NUM_CH-1:0]       lcrd_dec,
  input  logic                    deact_req,
  output logic [NUM_CH-1:0]       lcrd_avail,
  output logic [NUM_CH-1:0]       lcrd_full,
  output logic [NUM_CH*CNT_W-1:0] lcrd_cnt,
  output logic [NUM_CH-1:0]       lcrd_ret,
  output logic                    deact_done,
  output logic                    ovf_err,
  output logic                    unf_err
);

  lcrd_state_e       state_q, state_d;
  logic              cnt_load;
  logic [NUM_CH-1:0] dec_run;
  logic [NUM_CH-1:0] ch_not_zero, ch_ovf, ch_unf, ch_at_max;
  logic              all_zero;
  logic              ovf_err_q, ovf_err_d;
  logic              unf_err_q, unf_err_d;
  logic              deact_done_q, deact_done_d;

  assign all_zero = ~|ch_not_zero;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rni_lcrd_ch_ctr #(
      .CNT_W    (CNT_W),
      .INIT_VAL (LCRD_INIT_CNT_VAL),
      .MAX_VAL  (LCRD_MAX_CNT_VAL)
    ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .inc_i      (lcrd_inc[i]),
      .dec_i      (dec_run[i]),
      .ret_i      (lcrd_ret[i]),
      .cnt_o      (lcrd_cnt[i*CNT_W +: CNT_W]),
      .not_zero_o (ch_not_zero[i]),
      .ovf_o      (ch_ovf[i]),
      .unf_o      (ch_unf[i])
    );
    assign ch_at_max[i] = (lcrd_cnt[i*CNT_W +: CNT_W] == CNT_W'(LCRD_MAX_CNT_VAL));
  end

  // FSM state register; reset always lands in INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // FSM next state: deact_req low always returns to RUN with counts kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_RUN;
      ST_RUN:   if (deact_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!deact_req)                    state_d = ST_RUN;
        else if (all_zero && !(|lcrd_inc)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (!deact_req)     state_d = ST_RUN;
        else if (!all_zero) state_d = ST_DRAIN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs: counter controls and the same-cycle avail/full/ret flags.
  always_comb begin
    cnt_load   = 1'b0;
    dec_run    = '0;
    lcrd_avail = '0;
    lcrd_full  = '0;
    lcrd_ret   = '0;
    case (state_q)
      ST_INIT:  cnt_load = 1'b1;
      ST_RUN: begin
        dec_run    = lcrd_dec;
        lcrd_avail = (ch_not_zero | lcrd_inc) & {NUM_CH{~rst}};
        lcrd_full  = ~lcrd_dec & ch_at_max;
      end
      ST_DRAIN: lcrd_ret = ch_not_zero | lcrd_inc;
      default:  ;
    endcase
  end

  // Sticky errors; any dec outside RUN is an underflow even though it is ignored.
  always_comb begin
    ovf_err_d    = ovf_err_q | (|ch_ovf);
    unf_err_d    = unf_err_q | (|ch_unf) | ((state_q != ST_RUN) & (|lcrd_dec));
    deact_done_d = (state_d == ST_STOP);
  end

  // Registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_q    <= 1'b0;
      unf_err_q    <= 1'b0;
      deact_done_q <= 1'b0;
    end else begin
      ovf_err_q    <= ovf_err_d;
      unf_err_q    <= unf_err_d;
      deact_done_q <= deact_done_d;
    end
  end

  assign ovf_err    = ovf_err_q;
  assign unf_err    = unf_err_q;
  assign deact_done = deact_done_q;

`ifdef ASSERT_CHECKER_ON
  param_range_a: assert property (@(posedge clk)
    (NUM_CH >= 1) && (NUM_CH <= 8) && (LCRD_MAX_CNT_VAL >= 1) &&
    (LCRD_MAX_CNT_VAL <= 15) && (LCRD_MAX_CNT_VAL >= LCRD_INIT_CNT_VAL))
    else $error("rni_lcrd_mgr: parameter out of range");

  ret_only_drain_a: assert property (@(posedge clk) disable iff (rst)
    (|lcrd_ret) |-> (state_q == ST_DRAIN))
    else $error("rni_lcrd_mgr: lcrd_ret outside DRAIN");

  // Reported as a warning: the sticky ovf_err flag is the functional signal.
  inc_while_full_a: assert property (@(posedge clk) disable iff (rst)
    !(|(lcrd_inc & lcrd_full)))
    else $warning("rni_lcrd_mgr: credit received on a full channel");
`endif

endmodule

// File: tb/tb_rni_lcrd_mgr.sv
// Directed bench for rni_lcrd_mgr with NUM_CH=4, INIT=4, MAX=15.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the next rising edge.
module tb_rni_lcrd_mgr;

  logic        clk;
  logic        rst;
  logic [3:0]  lcrd_inc, lcrd_dec;
  logic        deact_req;
  logic [3:0]  lcrd_avail, lcrd_full, lcrd_ret;
  logic [15:0] lcrd_cnt;
  logic        deact_done, ovf_err, unf_err;

  int n_pass = 0;
  int n_chk  = 0;

  rni_lcrd_mgr #(
    .NUM_CH            (4),
    .LCRD_INIT_CNT_VAL (4),
    .LCRD_MAX_CNT_VAL  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lcrd_inc   (lcrd_inc),
    .lcrd_dec   (lcrd_dec),
    .deact_req  (deact_req),
    .lcrd_avail (lcrd_avail),
    .lcrd_full  (lcrd_full),
    .lcrd_cnt   (lcrd_cnt),
    .lcrd_ret   (lcrd_ret),
    .deact_done (deact_done),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lcrd_inc = '0; lcrd_dec = '0; deact_req = 1'b0;
    tick(); tick();
    n_chk++; if (lcrd_cnt !== 16'h0000) $display("FAIL rst_cnt: got %h want 0000", lcrd_cnt); else n_pass++;
    n_chk++; if ({lcrd_avail, lcrd_full, lcrd_ret} !== 12'h000)
      $display("FAIL rst_flags: avail/full/ret got %b/%b/%b want 0", lcrd_avail, lcrd_full, lcrd_ret); else n_pass++;
    n_chk++; if ({deact_done, ovf_err, unf_err} !== 3'b000)
      $display("FAIL rst_regs: done/ovf/unf got %b%b%b want 000", deact_done, ovf_err, unf_err); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (lcrd_avail !== 4'b0000) $display("FAIL init_avail: got %b want 0000", lcrd_avail); else n_pass++;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h4444) $display("FAIL init_load: got %h want 4444", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_avail !== 4'b1111) $display("FAIL init_avail_on: got %b want 1111", lcrd_avail); else n_pass++;
  endtask

  task automatic test_dec_to_zero();
    for (int i = 0; i < 4; i++) begin
      lcrd_dec = 4'b0001;
      #1;
      n_chk++; if (lcrd_avail[0] !== 1'b1) $display("FAIL dec_avail0 step %0d: got %b want 1", i, lcrd_avail[0]); else n_pass++;
      tick();
    end
    lcrd_dec = '0;
    #1;
    n_chk++; if (lcrd_cnt !== 16'h4440) $display("FAIL dec_cnt: got %h want 4440", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_avail !== 4'b1110) $display("FAIL dec_avail: got %b want 1110", lcrd_avail); else n_pass++;
    n_chk++; if (unf_err !== 1'b0) $display("FAIL dec_no_unf: got %b want 0", unf_err); else n_pass++;
  endtask

  task automatic test_saturation();
    lcrd_inc = 4'b0010;
    repeat (11) tick();
    lcrd_inc = '0;
    #1;
    n_chk++; if (lcrd_cnt !== 16'h44F0) $display("FAIL sat_fill: got %h want 44f0", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_full !== 4'b0010) $display("FAIL sat_full: got %b want 0010", lcrd_full); else n_pass++;
    n_chk++; if (ovf_err !== 1'b0) $display("FAIL sat_no_ovf_yet: got %b want 0", ovf_err); else n_pass++;
    lcrd_inc = 4'b0010;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h44F0) $display("FAIL sat_hold: got %h want 44f0", lcrd_cnt); else n_pass++;
    n_chk++; if (ovf_err !== 1'b1) $display("FAIL sat_ovf: got %b want 1", ovf_err); else n_pass++;
    lcrd_inc = 4'b0010; lcrd_dec = 4'b0010;
    #1;
    n_chk++; if (lcrd_full !== 4'b0000) $display("FAIL sat_full_dec: got %b want 0000", lcrd_full); else n_pass++;
    tick();
    lcrd_inc = '0; lcrd_dec = '0;
    #1;
    n_chk++; if (lcrd_cnt !== 16'h44F0) $display("FAIL sat_incdec: got %h want 44f0", lcrd_cnt); else n_pass++;
  endtask

  task automatic test_drain();
    logic [3:0] exp_ret  [4] = '{4'b1101, 4'b1001, 4'b0001, 4'b0000};
    logic       exp_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         pulses   [4] = '{0, 0, 0, 0};
    // From {ch3..ch0} = {4,4,15,0} build {2,1,0,3}.
    for (int k = 0; k < 15; k++) begin
      lcrd_inc = (k < 3) ? 4'b0001 : 4'b0000;
      lcrd_dec = 4'b0010 | ((k < 3) ? 4'b0100 : 4'b0000) | ((k < 2) ? 4'b1000 : 4'b0000);
      tick();
    end
    lcrd_inc = '0; lcrd_dec = '0;
    #1;
    n_chk++; if (lcrd_cnt !== 16'h2103) $display("FAIL drain_setup: got %h want 2103", lcrd_cnt); else n_pass++;
    deact_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (lcrd_ret !== exp_ret[i]) $display("FAIL drain_ret cyc %0d: got %b want %b", i, lcrd_ret, exp_ret[i]); else n_pass++;
      n_chk++; if (lcrd_avail !== 4'b0000) $display("FAIL drain_avail cyc %0d: got %b want 0000", i, lcrd_avail); else n_pass++;
      for (int c = 0; c < 4; c++) pulses[c] += int'(lcrd_ret[c]);
      tick();
      n_chk++; if (deact_done !== exp_done[i]) $display("FAIL drain_done cyc %0d: got %b want %b", i, deact_done, exp_done[i]); else n_pass++;
    end
    n_chk++; if ({pulses[3], pulses[2], pulses[1], pulses[0]} !== {32'd2, 32'd1, 32'd0, 32'd3})
      $display("FAIL drain_pulses: got %0d/%0d/%0d/%0d want 3/0/1/2", pulses[0], pulses[1], pulses[2], pulses[3]); else n_pass++;
    n_chk++; if (lcrd_cnt !== 16'h0000) $display("FAIL drain_empty: got %h want 0000", lcrd_cnt); else n_pass++;
  endtask

  task automatic test_drain_with_inc();
    lcrd_inc = 4'b0100;
    #1;
    n_chk++; if ({lcrd_ret, lcrd_avail} !== 8'h00) $display("FAIL stop_quiet: ret/avail got %b/%b want 0", lcrd_ret, lcrd_avail); else n_pass++;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h0100) $display("FAIL stop_accum: got %h want 0100", lcrd_cnt); else n_pass++;
    n_chk++; if (deact_done !== 1'b1) $display("FAIL stop_done: got %b want 1", deact_done); else n_pass++;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h0200) $display("FAIL stop_redrain_cnt: got %h want 0200", lcrd_cnt); else n_pass++;
    n_chk++; if (deact_done !== 1'b0) $display("FAIL stop_redrain_done: got %b want 0", deact_done); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (lcrd_ret !== 4'b0100) $display("FAIL incret_ret cyc %0d: got %b want 0100", i, lcrd_ret); else n_pass++;
      tick();
      n_chk++; if (lcrd_cnt !== 16'h0200) $display("FAIL incret_cnt cyc %0d: got %h want 0200", i, lcrd_cnt); else n_pass++;
    end
    lcrd_inc = '0;
    #1;
    n_chk++; if (lcrd_ret !== 4'b0100) $display("FAIL incret_tail0: got %b want 0100", lcrd_ret); else n_pass++;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h0100) $display("FAIL incret_cnt1: got %h want 0100", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_ret !== 4'b0100) $display("FAIL incret_tail1: got %b want 0100", lcrd_ret); else n_pass++;
    tick();
    n_chk++; if ({lcrd_cnt, lcrd_ret} !== 20'h0) $display("FAIL incret_empty: cnt/ret got %h/%b want 0", lcrd_cnt, lcrd_ret); else n_pass++;
    tick();
    n_chk++; if (deact_done !== 1'b1) $display("FAIL incret_done: got %b want 1", deact_done); else n_pass++;
    n_chk++; if ({ovf_err, unf_err} !== 2'b10) $display("FAIL incret_errs: ovf/unf got %b%b want 10", ovf_err, unf_err); else n_pass++;
  endtask

  task automatic test_drain_exit();
    lcrd_inc = 4'b0001;
    tick();
    tick();
    // Now in DRAIN with cnt0=2; inc cancels the return, dec must be ignored.
    lcrd_inc = 4'b0001; lcrd_dec = 4'b0001; deact_req = 1'b0;
    #1;
    n_chk++; if (lcrd_ret !== 4'b0001) $display("FAIL exit_ret: got %b want 0001", lcrd_ret); else n_pass++;
    n_chk++; if (lcrd_avail !== 4'b0000) $display("FAIL exit_avail_drain: got %b want 0000", lcrd_avail); else n_pass++;
    tick();
    lcrd_inc = '0; lcrd_dec = '0;
    #1;
    n_chk++; if (lcrd_cnt !== 16'h0002) $display("FAIL exit_cnt: got %h want 0002", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_avail !== 4'b0001) $display("FAIL exit_avail_run: got %b want 0001", lcrd_avail); else n_pass++;
    n_chk++; if (unf_err !== 1'b1) $display("FAIL exit_unf: got %b want 1", unf_err); else n_pass++;
    n_chk++; if (deact_done !== 1'b0) $display("FAIL exit_done: got %b want 0", deact_done); else n_pass++;
  endtask

  task automatic test_rst_mid_drain();
    deact_req = 1'b1;
    tick();
    n_chk++; if (lcrd_ret !== 4'b0001) $display("FAIL rstd_ret_pre: got %b want 0001", lcrd_ret); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (lcrd_ret !== 4'b0000) $display("FAIL rstd_ret: got %b want 0000", lcrd_ret); else n_pass++;
    n_chk++; if (lcrd_cnt !== 16'h0000) $display("FAIL rstd_cnt: got %h want 0000", lcrd_cnt); else n_pass++;
    n_chk++; if ({ovf_err, unf_err} !== 2'b00) $display("FAIL rstd_errs: ovf/unf got %b%b want 00", ovf_err, unf_err); else n_pass++;
    deact_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_chk++; if ({lcrd_avail, lcrd_cnt} !== 20'h0) $display("FAIL rstd_init: avail/cnt got %b/%h want 0", lcrd_avail, lcrd_cnt); else n_pass++;
    tick();
    n_chk++; if (lcrd_cnt !== 16'h4444) $display("FAIL rstd_reload: got %h want 4444", lcrd_cnt); else n_pass++;
    n_chk++; if (lcrd_avail !== 4'b1111) $display("FAIL rstd_avail: got %b want 1111", lcrd_avail); else n_pass++;
    n_chk++; if (deact_done !== 1'b0) $display("FAIL rstd_done: got %b want 0", deact_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dec_to_zero();
    test_saturation();
    test_drain();
    test_drain_with_inc();
    test_drain_exit();
    test_rst_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
